// File: rtl/instr_prefetch_reg_if.sv
// Instruction prefetch register bus interface.
// Groups the control strobes, the bus input and the status/IR outputs of
// instr_prefetch_reg. The tri-state operand bus DATA_OUT stays a plain port
// on the module so the release to Z resolves on an ordinary net.
//   master : drives LOAD/ADVANCE/FLUSH/COUNT/ENABLE/DATA_IN, observes status
//   slave  : the prefetch register itself
interface instr_prefetch_reg_if #(
  parameter int unsigned BUS_WIDTH = 16,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic                 LOAD;
  logic                 ADVANCE;
  logic                 FLUSH;
  logic                 COUNT;
  logic                 ENABLE;
  logic [BUS_WIDTH-1:0] DATA_IN;
  logic [BUS_WIDTH-1:0] INSTRUCTION_OUT;
  logic                 IR_VALID;
  logic [LVL_W-1:0]     LEVEL;
  logic                 FULL;
  logic                 EMPTY;
  logic                 OVERFLOW;

  modport master (
    output LOAD, ADVANCE, FLUSH, COUNT, ENABLE, DATA_IN,
    input  INSTRUCTION_OUT, IR_VALID, LEVEL, FULL, EMPTY, OVERFLOW
  );

  modport slave (
    input  LOAD, ADVANCE, FLUSH, COUNT, ENABLE, DATA_IN,
    output INSTRUCTION_OUT, IR_VALID, LEVEL, FULL, EMPTY, OVERFLOW
  );
endinterface

// File: rtl/instr_prefetch_reg.sv
// Instruction prefetch register: a DEPTH-entry prefetch queue feeding an
// instruction register (IR) with optional increment and a tri-state operand
// output.
// Ports:
//   CLOCK    rising-edge clock
//   RESET    asynchronous reset, active-high
//   bus      instr_prefetch_reg_if.slave (LOAD, ADVANCE, FLUSH, COUNT,
//            ENABLE, DATA_IN in; INSTRUCTION_OUT, IR_VALID, LEVEL, FULL,
//            EMPTY, OVERFLOW out)
//   DATA_OUT operand field of IR, released to Z when ENABLE is low
// Build option: define IR_SIGN_EXT_EN to sign-extend the operand on DATA_OUT
// instead of zero-filling the opcode bits.
module instr_prefetch_reg #(
  parameter int unsigned BUS_WIDTH    = 16,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned COUNT_EN     = 1
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  instr_prefetch_reg_if.slave    bus,
  output wire  [BUS_WIDTH-1:0]   DATA_OUT
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned OPND_W = BUS_WIDTH - OPCODE_WIDTH;

  logic [BUS_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [BUS_WIDTH-1:0] ir_q, ir_d;
  logic                 ir_valid_q, ir_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 mem_we;
  logic                 full, empty;
  logic [OPND_W-1:0]    operand;
  logic [BUS_WIDTH-1:0] operand_ext;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // Next-state: FLUSH wins, then LOAD/ADVANCE, COUNT only when IR is not reloaded
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;

    if (bus.FLUSH) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      ir_valid_d = 1'b0;
      overflow_d = 1'b0;
    end else if (bus.ADVANCE) begin
      if (empty) begin
        // Empty queue: a same-cycle LOAD bypasses straight into IR
        ir_valid_d = bus.LOAD;
        if (bus.LOAD) begin
          ir_d = bus.DATA_IN;
        end
      end else begin
        ir_d       = mem_q[rd_ptr_q];
        ir_valid_d = 1'b1;
        rd_ptr_d   = PTR_W'(rd_ptr_q + 1'b1);
        // A pop frees a slot, so a concurrent push always fits (even when full)
        if (bus.LOAD) begin
          mem_we   = 1'b1;
          wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
        end else begin
          level_d  = LVL_W'(level_q - 1'b1);
        end
      end
    end else begin
      if (bus.LOAD) begin
        if (!full) begin
          mem_we   = 1'b1;
          wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
          level_d  = LVL_W'(level_q + 1'b1);
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (bus.COUNT && (COUNT_EN != 0)) begin
        ir_d = BUS_WIDTH'(ir_q + 1'b1);
      end
    end
  end

  // Control state; reset discards the queue by zeroing pointers and level
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Queue storage needs no reset: nothing is read past the level count
  always_ff @(posedge CLOCK) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= bus.DATA_IN;
    end
  end

  assign operand = ir_q[OPND_W-1:0];
`ifdef IR_SIGN_EXT_EN
  assign operand_ext = {{OPCODE_WIDTH{operand[OPND_W-1]}}, operand};
`else
  assign operand_ext = {{OPCODE_WIDTH{1'b0}}, operand};
`endif

  assign DATA_OUT = bus.ENABLE ? operand_ext : {BUS_WIDTH{1'bz}};

  assign bus.INSTRUCTION_OUT = ir_q;
  assign bus.IR_VALID        = ir_valid_q;
  assign bus.LEVEL           = level_q;
  assign bus.FULL            = full;
  assign bus.EMPTY           = empty;
  assign bus.OVERFLOW        = overflow_q;
endmodule

// File: doc/instr_prefetch_reg.md
INSTR_PREFETCH_REG -- requirements
Module: instr_prefetch_reg

Interface
REQ-001 Parameter BUS_WIDTH, default 16, SHALL set the data bus and instruction width.
REQ-002 Parameter OPCODE_WIDTH, default 4, SHALL set the number of opcode MSBs; operand width is BUS_WIDTH-OPCODE_WIDTH.
REQ-003 Parameter DEPTH, default 4, SHALL set the prefetch queue depth (power of two, >=2).
REQ-004 Parameter COUNT_EN, default 1, SHALL enable IR increment when nonzero.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high. Ports:
- CLOCK  in  1  rising-edge clock
- RESET  in  1  asynchronous reset, active-high
- LOAD  in  1  push DATA_IN into queue
- ADVANCE  in  1  pop queue head into IR
- FLUSH  in  1  discard queue contents
- COUNT  in  1  increment IR
- ENABLE  in  1  drive operand onto DATA_OUT
- DATA_IN  in  BUS_WIDTH  bus input
- DATA_OUT  out  BUS_WIDTH  operand field, tri-stated when ENABLE low
- INSTRUCTION_OUT  out  BUS_WIDTH  current IR value
- IR_VALID  out  1  IR holds a fetched instruction
- LEVEL  out  clog2(DEPTH)+1  queue occupancy
- FULL, EMPTY  out  1  LEVEL==DEPTH, LEVEL==0
- OVERFLOW  out  1  sticky: LOAD attempted while full

Function
REQ-006 Priority per edge SHALL be: RESET > FLUSH > LOAD/ADVANCE > COUNT.
REQ-007 LOAD with queue not full SHALL write DATA_IN at tail; LEVEL+1 next cycle.
REQ-008 LOAD while full without same-cycle ADVANCE SHALL drop data and set OVERFLOW.
REQ-009 ADVANCE with queue not empty SHALL load head into IR, set IR_VALID, LEVEL-1, in one cycle.
REQ-010 ADVANCE and LOAD while empty SHALL bypass DATA_IN directly into IR, IR_VALID=1, LEVEL stays 0.
REQ-011 ADVANCE and LOAD while full SHALL both succeed; LEVEL stays DEPTH; OVERFLOW unchanged.
REQ-012 ADVANCE alone while empty SHALL clear IR_VALID and hold IR value.
REQ-013 COUNT with COUNT_EN nonzero and no ADVANCE/FLUSH SHALL set IR to IR+1 modulo 2^BUS_WIDTH (all-ones wraps to 0); IR_VALID unchanged.
REQ-014 COUNT SHALL be ignored when COUNT_EN is 0.
REQ-015 FLUSH SHALL set LEVEL=0, clear OVERFLOW and IR_VALID, hold IR value, and ignore same-cycle LOAD, ADVANCE, COUNT.
REQ-016 Read/write pointers SHALL wrap modulo DEPTH.
REQ-017 DATA_OUT SHALL combinationally equal the low BUS_WIDTH-OPCODE_WIDTH IR bits, upper OPCODE_WIDTH bits zero, when ENABLE=1; all Z when ENABLE=0.
REQ-018 INSTRUCTION_OUT SHALL always equal IR, independent of ENABLE.
REQ-019 FULL, EMPTY, LEVEL, IR_VALID, OVERFLOW SHALL be registered-state derived, no combinational path from inputs.

Reset
REQ-020 RESET high SHALL immediately, without clock, set IR=0, LEVEL=0, pointers=0, IR_VALID=0, OVERFLOW=0, EMPTY=1, FULL=0.
REQ-021 RESET asserted mid-operation SHALL discard queued words; queue storage need not be cleared.
REQ-022 The first edge after RESET falls SHALL obey REQ-006..REQ-016 normally.

Configuration
REQ-023 Macro IR_SIGN_EXT_EN defined: DATA_OUT upper OPCODE_WIDTH bits SHALL replicate operand MSB (sign extension).
REQ-024 Macro IR_SIGN_EXT_EN undefined: DATA_OUT upper bits SHALL be zero per REQ-017.

Verification (BUS_WIDTH=16, OPCODE_WIDTH=4, DEPTH=4)
REQ-025 LOAD 0x1001,0x2002,0x3003,0x4004 -> FULL=1, LEVEL=4; 5th LOAD 0x5005 -> OVERFLOW=1, LEVEL=4; four ADVANCEs -> IR 0x1001..0x4004 in order.
REQ-026 Empty queue, LOAD+ADVANCE with 0xA123 -> IR=0xA123, IR_VALID=1, LEVEL=0; ENABLE=1 -> DATA_OUT=0x0123 (0xF123 with IR_SIGN_EXT_EN only if bit 11 set; 0xA823 -> 0xF823).
REQ-027 IR=0xFFFF, COUNT -> IR=0x0000; same-cycle ADVANCE+COUNT with head 0x7000 -> IR=0x7000 (no increment).
REQ-028 LEVEL=2, OVERFLOW=1, FLUSH with LOAD -> LEVEL=0, EMPTY=1, OVERFLOW=0, IR_VALID=0, IR unchanged.
REQ-029 RESET pulsed between clock edges with LEVEL=3 -> all outputs at reset values before next edge; ENABLE=0 -> DATA_OUT all Z.
